// File: rtl/mesh_term_arbiter.sv
// mesh_term_arbiter
//   Round-robin arbiter sharing one mesh terminal input port between N_REQ
//   local FWFT packet FIFOs. The winning FIFO is popped, its head packet is
//   registered and offered to the router with the pdng/popin handshake. The
//   packet is held until the router consumes it. Includes a stall watchdog
//   and a delivered-packet counter.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_pndng_i  per-requester FIFO non-empty
//   req_data_i   per-requester FIFO head, requester k at [k*PKG_W +: PKG_W]
//   req_pop_o    one-cycle pop to the winning FIFO (onehot or zero, combinational)
//   pdng_o       packet pending to router
//   data_o       registered packet to router
//   popin_i      router consumed data_o this cycle
//   grant_id_o   source index of the packet on data_o
//   stall_o      data_o offered for TIMEOUT cycles without being consumed
//   pkt_cnt_o    delivered packets, wraps at 2^16
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | nothing offered, pdng_o = 0
// OFFER | packet in data_o offered, pdng_o = 1

module mesh_term_arbiter #(
  parameter int N_REQ   = 4,
  parameter int PKG_W   = 40,
  parameter int TIMEOUT = 255,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_pndng_i,
  input  logic [N_REQ*PKG_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]         req_pop_o,
  output logic                     pdng_o,
  output logic [PKG_W-1:0]         data_o,
  input  logic                     popin_i,
  output logic [ID_W-1:0]          grant_id_o,
  output logic                     stall_o,
  output logic [15:0]              pkt_cnt_o
);

  localparam logic IDLE  = 1'b0;
  localparam logic OFFER = 1'b1;

  logic             state;
  logic [ID_W-1:0]  last_grant;
  logic [15:0]      wait_cnt;
  logic [ID_W-1:0]  winner;
  logic [PKG_W-1:0] win_data;
  logic             found;
  logic             any_req;
  logic             load;
  int               cand;

  assign any_req = |req_pndng_i;
  // A new packet may only be taken when nothing is outstanding or the
  // current one is being consumed in this very cycle.
  assign load    = any_req & ((state == IDLE) | popin_i);

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req_pndng_i[ID_W'(cand)]) begin
        winner = ID_W'(cand);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    win_data  = '0;
    req_pop_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == ID_W'(k)) begin
        win_data     = req_data_i[k*PKG_W +: PKG_W];
        req_pop_o[k] = load;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      data_o     <= '0;
      grant_id_o <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else if (load) begin
      state      <= OFFER;
      data_o     <= win_data;
      grant_id_o <= winner;
      last_grant <= winner;
    end else if (state == OFFER && popin_i) begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt_o <= '0;
    end else if (state == OFFER && popin_i) begin
      pkt_cnt_o <= pkt_cnt_o + 16'd1;
    end
  end

  // Wait counter restarts with every new packet and after every consumption;
  // it saturates so a very long stall never wraps stall_o back low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (load || (state == OFFER && popin_i)) begin
      wait_cnt <= '0;
    end else if (state == OFFER && wait_cnt != 16'hFFFF) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign pdng_o  = (state == OFFER);
  assign stall_o = (wait_cnt >= 16'(TIMEOUT));

endmodule
